// File: rtl/select_n_pipe_wn.sv
// Registered N-way select with a 2-entry (output + skid) valid/ready buffer.
// Optional one-hot checking is enabled by defining SELECT_N_PIPE_ONEHOT_CHECK_EN.
module select_n_pipe_wn #(
    parameter int DWIDTH       = 32,
    parameter int NUM_IN       = 4,
    parameter int ZERO_ON_NONE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IN*DWIDTH-1:0]   i_data,
    input  logic [NUM_IN-1:0]          i_enable,
    input  logic                       i_valid,
    output logic                       i_ready,
    output logic [DWIDTH-1:0]          o_data,
    output logic [$clog2(NUM_IN)-1:0]  o_idx,
    output logic                       o_none,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic                       err_multi,
    output logic [7:0]                 err_count
);

    localparam int   IW     = $clog2(NUM_IN);
    localparam logic ZON_EN = (ZERO_ON_NONE != 0);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL1 = 2'd1;
    localparam logic [1:0] ST_FULL2 = 2'd2;

    // Scans from the top so the lowest set bit is the last one written.
    function automatic logic [IW-1:0] lowest_set(input logic [NUM_IN-1:0] vec);
        logic [IW-1:0] idx;
        idx = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = vec[k] ? IW'(k) : idx;
        end
        return idx;
    endfunction

    function automatic logic is_multi_hot(input logic [NUM_IN-1:0] vec);
        return (vec & (vec - NUM_IN'(1))) != '0;
    endfunction

    logic [1:0]        state_r, state_s;
    logic              ready_r, valid_r;
    logic [DWIDTH-1:0] out_data_r, skid_data_r, sel_data_s;
    logic [IW-1:0]     out_idx_r, skid_idx_r, sel_idx_s;
    logic              out_none_r, skid_none_r;
    logic              sel_any_s, store_s, accept_s;
    logic              ld_new_s, ld_skid_s, ld_skid_out_s;

    // Lowest-index select; no enable gives zero data and index 0.
    always_comb begin
        sel_any_s  = |i_enable;
        sel_idx_s  = lowest_set(i_enable);
        sel_data_s = sel_any_s ? i_data[sel_idx_s*DWIDTH +: DWIDTH] : {DWIDTH{1'b0}};
        accept_s   = i_valid && ready_r;
        store_s    = accept_s && (sel_any_s || ZON_EN);
    end

    // Buffer occupancy next-state and register load controls.
    always_comb begin
        state_s       = state_r;
        ld_new_s      = 1'b0;
        ld_skid_s     = 1'b0;
        ld_skid_out_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (store_s) begin
                    state_s  = ST_FULL1;
                    ld_new_s = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_FULL1: begin
                if (o_ready && store_s) begin
                    state_s  = ST_FULL1;
                    ld_new_s = 1'b1;
                end else if (o_ready) begin
                    state_s = ST_EMPTY;
                end else if (store_s) begin
                    state_s   = ST_FULL2;
                    ld_skid_s = 1'b1;
                end else begin
                    state_s = ST_FULL1;
                end
            end
            ST_FULL2: begin
                if (o_ready) begin
                    state_s       = ST_FULL1;
                    ld_skid_out_s = 1'b1;
                end else begin
                    state_s = ST_FULL2;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // State plus handshake flags, all taken from the next state so they stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s != ST_FULL2);
            valid_r <= (state_s != ST_EMPTY);
        end
    end

    // Output register: new beat, or the skid entry when draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r <= {DWIDTH{1'b0}};
            out_idx_r  <= {IW{1'b0}};
            out_none_r <= 1'b0;
        end else if (ld_new_s) begin
            out_data_r <= sel_data_s;
            out_idx_r  <= sel_idx_s;
            out_none_r <= !sel_any_s;
        end else if (ld_skid_out_s) begin
            out_data_r <= skid_data_r;
            out_idx_r  <= skid_idx_r;
            out_none_r <= skid_none_r;
        end else begin
            out_data_r <= out_data_r;
            out_idx_r  <= out_idx_r;
            out_none_r <= out_none_r;
        end
    end

    // Skid entry captures a beat accepted while the output is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_data_r <= {DWIDTH{1'b0}};
            skid_idx_r  <= {IW{1'b0}};
            skid_none_r <= 1'b0;
        end else if (ld_skid_s) begin
            skid_data_r <= sel_data_s;
            skid_idx_r  <= sel_idx_s;
            skid_none_r <= !sel_any_s;
        end else begin
            skid_data_r <= skid_data_r;
            skid_idx_r  <= skid_idx_r;
            skid_none_r <= skid_none_r;
        end
    end

    assign i_ready = ready_r;
    assign o_valid = valid_r;
    assign o_data  = out_data_r;
    assign o_idx   = out_idx_r;
    assign o_none  = out_none_r;

`ifdef SELECT_N_PIPE_ONEHOT_CHECK_EN
    logic       err_multi_r;
    logic [7:0] err_count_r;

    // Sticky flag and saturating count of accepted multi-hot beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_multi_r <= 1'b0;
            err_count_r <= 8'd0;
        end else if (accept_s && is_multi_hot(i_enable)) begin
            err_multi_r <= 1'b1;
            err_count_r <= (err_count_r == 8'd255) ? 8'd255 : err_count_r + 8'd1;
        end else begin
            err_multi_r <= err_multi_r;
            err_count_r <= err_count_r;
        end
    end

    assign err_multi = err_multi_r;
    assign err_count = err_count_r;
`else
    assign err_multi = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_select_n_pipe_wn.sv
// Directed bench for select_n_pipe_wn: streaming, backpressure, no-enable, multi-hot, reset.
module tb_select_n_pipe_wn;

    logic          clk = 1'b0;
    logic          reset;
    logic [127:0]  i_data;
    logic [3:0]    i_enable;
    logic          i_valid, i_valid0;
    logic          o_ready;
    logic          i_ready, o_none, o_valid, err_multi;
    logic [31:0]   o_data;
    logic [1:0]    o_idx;
    logic [7:0]    err_count;
    logic          i_ready0, o_none0, o_valid0, err_multi0;
    logic [31:0]   o_data0;
    logic [1:0]    o_idx0;
    logic [7:0]    err_count0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    select_n_pipe_wn #(.DWIDTH(32), .NUM_IN(4), .ZERO_ON_NONE(1)) dut (
        .clk(clk), .reset(reset), .i_data(i_data), .i_enable(i_enable),
        .i_valid(i_valid), .i_ready(i_ready), .o_data(o_data), .o_idx(o_idx),
        .o_none(o_none), .o_valid(o_valid), .o_ready(o_ready),
        .err_multi(err_multi), .err_count(err_count)
    );

    select_n_pipe_wn #(.DWIDTH(32), .NUM_IN(4), .ZERO_ON_NONE(0)) dut_drop (
        .clk(clk), .reset(reset), .i_data(i_data), .i_enable(i_enable),
        .i_valid(i_valid0), .i_ready(i_ready0), .o_data(o_data0), .o_idx(o_idx0),
        .o_none(o_none0), .o_valid(o_valid0), .o_ready(1'b1),
        .err_multi(err_multi0), .err_count(err_count0)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_err(input string tag, input logic exp_multi, input logic [7:0] exp_cnt);
`ifdef SELECT_N_PIPE_ONEHOT_CHECK_EN
        check_eq({tag, "_multi"}, 32'(err_multi), 32'(exp_multi));
        check_eq({tag, "_count"}, 32'(err_count), 32'(exp_cnt));
`else
        check_eq({tag, "_multi"}, 32'(err_multi), 32'd0);
        check_eq({tag, "_count"}, 32'(err_count), 32'd0);
`endif
    endtask

    initial begin
        reset    = 1'b1;
        i_data   = 128'd0;
        i_enable = 4'b0000;
        i_valid  = 1'b0;
        i_valid0 = 1'b0;
        o_ready  = 1'b1;
        #12;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_data", o_data, 32'd0);
        check_eq("rst_idx", 32'(o_idx), 32'd0);
        check_eq("rst_none", 32'(o_none), 32'd0);
        check_eq("rst_ready", 32'(i_ready), 32'd1);
        check_err("rst_err", 1'b0, 8'd0);
        step();
        reset = 1'b0;

        // streaming with enable 0100
        i_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        i_enable = 4'b0100;
        i_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("stream_valid", 32'(o_valid), 32'd1);
            check_eq("stream_data", o_data, 32'h33);
            check_eq("stream_idx", 32'(o_idx), 32'd2);
        end
        i_valid = 1'b0;
        step();
        check_eq("stream_drain", 32'(o_valid), 32'd0);

        // backpressure: A, B accepted, C held upstream
        i_data   = {32'h44, 32'hCC, 32'hBB, 32'hAA};
        o_ready  = 1'b0;
        i_enable = 4'b0001;
        i_valid  = 1'b1;
        step();
        check_eq("bp_a_data", o_data, 32'hAA);
        check_eq("bp_a_ready", 32'(i_ready), 32'd1);
        i_enable = 4'b0010;
        step();
        check_eq("bp_b_ready", 32'(i_ready), 32'd0);
        check_eq("bp_b_hold", o_data, 32'hAA);
        i_enable = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            step();
            check_eq("bp_stall_data", o_data, 32'hAA);
            check_eq("bp_stall_idx", 32'(o_idx), 32'd0);
            check_eq("bp_stall_ready", 32'(i_ready), 32'd0);
        end
        o_ready = 1'b1;
        step();
        check_eq("bp_out_b", o_data, 32'hBB);
        check_eq("bp_out_b_valid", 32'(o_valid), 32'd1);
        check_eq("bp_out_b_ready", 32'(i_ready), 32'd1);
        step();
        check_eq("bp_out_c", o_data, 32'hCC);
        check_eq("bp_out_c_idx", 32'(o_idx), 32'd2);
        i_valid = 1'b0;
        step();
        check_eq("bp_empty", 32'(o_valid), 32'd0);

        // no enable, zero-on-none variant
        i_data   = {128{1'b1}};
        i_enable = 4'b0000;
        i_valid  = 1'b1;
        step();
        check_eq("none_valid", 32'(o_valid), 32'd1);
        check_eq("none_data", o_data, 32'd0);
        check_eq("none_flag", 32'(o_none), 32'd1);
        check_eq("none_idx", 32'(o_idx), 32'd0);
        i_valid = 1'b0;
        step();

        // no enable, drop variant
        i_valid0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("drop_valid", 32'(o_valid0), 32'd0);
            check_eq("drop_ready", 32'(i_ready0), 32'd1);
        end
        i_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        i_enable = 4'b0001;
        step();
        check_eq("drop_en_valid", 32'(o_valid0), 32'd1);
        check_eq("drop_en_data", o_data0, 32'h11);
        i_valid0 = 1'b0;

        // multi-hot 1010 selects word 1
        i_enable = 4'b1010;
        i_valid  = 1'b1;
        step();
        check_eq("multi_idx", 32'(o_idx), 32'd1);
        check_eq("multi_data", o_data, 32'h22);
        check_eq("multi_none", 32'(o_none), 32'd0);
        check_err("multi_one", 1'b1, 8'd1);
        for (int k = 0; k < 299; k++) begin
            step();
        end
        check_err("multi_sat", 1'b1, 8'd255);
        i_valid = 1'b0;
        step();

        // reset with two beats buffered
        i_data   = {32'h44, 32'hCC, 32'hBB, 32'hAA};
        o_ready  = 1'b0;
        i_enable = 4'b0001;
        i_valid  = 1'b1;
        step();
        i_enable = 4'b0010;
        step();
        check_eq("full2_ready", 32'(i_ready), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("arst_valid", 32'(o_valid), 32'd0);
        check_eq("arst_ready", 32'(i_ready), 32'd1);
        check_eq("arst_data", o_data, 32'd0);
        check_err("arst_err", 1'b0, 8'd0);
        i_valid = 1'b0;
        step();
        reset   = 1'b0;
        o_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("post_rst_valid", 32'(o_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
